event_timer_mc: RTL and testbench

- Multi-channel programmable down-counting event timer with a shared prescaler and per-channel one-shot/periodic mode.
- Generates single-cycle event pulses for SoC peripherals, e.g. sample strobes, timeouts and watchdog-style ticks.
- Sits in the SoC peripheral/clock-domain glue; config comes from register-file outputs held stable by software.

---
 rtl/event_timer_pkg.sv | 5 +
 rtl/event_timer_ch.sv | 44 ++++
 rtl/event_timer_mc.sv | 53 +++++
 tb/tb_event_timer_mc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/event_timer_pkg.sv
// event_timer_pkg: shared types for the multi-channel event timer.
package event_timer_pkg;
  typedef enum logic {ONE_SHOT, PERIODIC} mode_e;
  typedef enum logic {IDLE, RUN} ch_state_e;
endpackage

// File: rtl/event_timer_ch.sv
// event_timer_ch: one timer channel with its FSM, down-counter and registered event pulse.
module event_timer_ch
  import event_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int CNT_INIT  = 15
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode,
  input  logic [CNT_WIDTH-1:0] reload,
  output logic                 ev,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] cnt
);
  ch_state_e state, state_n;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic term;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else state <= state_n;
  end
  // stop beats start beats tick; a terminal tick only fires when neither pulse is present
  always_comb begin
    term    = (state == RUN) && tick && (cnt == '0) && !start && !stop;
    state_n = stop ? IDLE : start ? RUN : (term && mode == ONE_SHOT) ? IDLE : state;
    cnt_n   = stop ? cnt : start ? reload :
              (state == RUN && tick) ? ((cnt != '0) ? cnt - CNT_WIDTH'(1) :
                                        (mode == PERIODIC) ? reload : cnt) : cnt;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= CNT_WIDTH'(CNT_INIT);
      ev  <= 1'b0;
    end else begin
      cnt <= cnt_n;
      ev  <= term;
    end
  end
  always_comb busy = (state == RUN);
endmodule

// File: rtl/event_timer_mc.sv
// event_timer_mc: N_CH down-counting event timers sharing one prescaler tick.
// Macro EVENT_TIMER_PRESCALER_EN enables the prescaler; otherwise every cycle is a tick.
module event_timer_mc
  import event_timer_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int CNT_INIT    = 15,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [PRESC_WIDTH-1:0]    cfg_presc_i,
  input  logic [N_CH*CNT_WIDTH-1:0] cfg_reload_i,
  input  logic [N_CH-1:0]           cfg_mode_i,
  input  logic [N_CH-1:0]           start_i,
  input  logic [N_CH-1:0]           stop_i,
  output logic [N_CH-1:0]           event_o,
  output logic [N_CH-1:0]           busy_o,
  output logic [N_CH*CNT_WIDTH-1:0] cnt_o
);
  logic tick;
`ifdef EVENT_TIMER_PRESCALER_EN
  logic [PRESC_WIDTH-1:0] presc_cnt;
  always_comb tick = (presc_cnt == cfg_presc_i);
  // a divisor lowered below the current count wraps silently rather than ticking
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) presc_cnt <= '0;
    else presc_cnt <= (tick || presc_cnt > cfg_presc_i) ? '0 : presc_cnt + PRESC_WIDTH'(1);
  end
`else
  logic unused_presc;
  always_comb unused_presc = ^cfg_presc_i;
  always_comb tick = 1'b1;
`endif
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    event_timer_ch #(
      .CNT_WIDTH(CNT_WIDTH),
      .CNT_INIT (CNT_INIT)
    ) u_ch (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .tick  (tick),
      .start (start_i[i]),
      .stop  (stop_i[i]),
      .mode  (cfg_mode_i[i]),
      .reload(cfg_reload_i[i*CNT_WIDTH +: CNT_WIDTH]),
      .ev    (event_o[i]),
      .busy  (busy_o[i]),
      .cnt   (cnt_o[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end
endmodule

// File: tb/tb_event_timer_mc.sv
// tb_event_timer_mc: directed vector table on channel 0 plus hand sequences for timing corners.
module tb_event_timer_mc;
  localparam int N_CH = 4;
  localparam int CW   = 16;
  localparam int PW   = 8;
`ifdef EVENT_TIMER_PRESCALER_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn_i;
  logic [PW-1:0]    cfg_presc_i;
  logic [N_CH*CW-1:0] cfg_reload_i;
  logic [N_CH-1:0]  cfg_mode_i, start_i, stop_i, event_o, busy_o;
  logic [N_CH*CW-1:0] cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  event_timer_mc #(.N_CH(N_CH), .CNT_WIDTH(CW), .CNT_INIT(15), .PRESC_WIDTH(PW)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .cfg_presc_i (cfg_presc_i),
    .cfg_reload_i(cfg_reload_i),
    .cfg_mode_i  (cfg_mode_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .event_o     (event_o),
    .busy_o      (busy_o),
    .cnt_o       (cnt_o)
  );

  typedef struct {
    logic          start, stop, mode;
    logic [CW-1:0] reload;
    logic          ev, busy;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic s, input logic p, input logic m, input int rl,
                              input logic e, input logic b, input int c);
    vec_t v;
    v.start = s; v.stop = p; v.mode = m; v.reload = CW'(rl);
    v.ev = e; v.busy = b; v.cnt = CW'(c);
    return v;
  endfunction

  function automatic int eff(input int p);
    return PEN ? p : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    for (int k = 0; k < N_CH; k++) chk($sformatf("%s_cnt%0d", tag, k), 32'(cnt_o[k*CW +: CW]), 32'd15);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_event"}, 32'(event_o), 32'd0);
  endtask

  initial begin
    int n_ev, lat, k;
    bit seen;
    vecs[0]  = mk(1, 0, 1, 2, 0, 1, 2);
    vecs[1]  = mk(0, 0, 1, 2, 0, 1, 1);
    vecs[2]  = mk(0, 0, 1, 2, 0, 1, 0);
    vecs[3]  = mk(0, 0, 1, 2, 1, 1, 2);
    vecs[4]  = mk(0, 0, 1, 2, 0, 1, 1);
    vecs[5]  = mk(0, 0, 1, 2, 0, 1, 0);
    vecs[6]  = mk(1, 0, 1, 2, 0, 1, 2);
    vecs[7]  = mk(0, 0, 1, 2, 0, 1, 1);
    vecs[8]  = mk(0, 1, 1, 2, 0, 0, 1);
    vecs[9]  = mk(0, 0, 1, 2, 0, 0, 1);
    vecs[10] = mk(1, 0, 0, 1, 0, 1, 1);
    vecs[11] = mk(0, 0, 0, 1, 0, 1, 0);
    vecs[12] = mk(0, 0, 0, 1, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 1, 0, 0, 0);
    vecs[14] = mk(1, 0, 1, 0, 0, 1, 0);
    vecs[15] = mk(0, 0, 1, 0, 1, 1, 0);
    vecs[16] = mk(0, 0, 1, 0, 1, 1, 0);
    vecs[17] = mk(1, 0, 1, 0, 0, 1, 0);
    vecs[18] = mk(0, 0, 1, 0, 1, 1, 0);
    vecs[19] = mk(0, 1, 1, 0, 0, 0, 0);
    vecs[20] = mk(1, 1, 1, 3, 0, 0, 0);
    vecs[21] = mk(1, 0, 1, 3, 0, 1, 3);
    vecs[22] = mk(1, 0, 1, 1, 0, 1, 1);
    vecs[23] = mk(0, 0, 1, 1, 0, 1, 0);
    vecs[24] = mk(0, 0, 1, 1, 1, 1, 1);

    rstn_i = 1'b0; cfg_presc_i = '0; cfg_reload_i = '0; cfg_mode_i = '0;
    start_i = '0; stop_i = '0;
    #12;
    chk_reset_state("rst");
    step();
    rstn_i = 1'b1;
    n_ev = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (event_o != '0) n_ev++;
    end
    chk("idle_no_events", 32'(n_ev), 32'd0);
    chk_reset_state("idle");

    // vector table on channel 0 with a tick every cycle
    for (int i = 0; i < 25; i++) begin
      start_i[0] = vecs[i].start; stop_i[0] = vecs[i].stop;
      cfg_mode_i[0] = vecs[i].mode; cfg_reload_i[0 +: CW] = vecs[i].reload;
      step();
      start_i[0] = 1'b0; stop_i[0] = 1'b0;
      chk($sformatf("vec%0d_event", i), 32'(event_o[0]), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_busy", i), 32'(busy_o[0]), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt_o[0 +: CW]), 32'(vecs[i].cnt));
    end
    chk("vec_ch1_untouched", 32'(cnt_o[CW +: CW]), 32'd15);

    // periodic reload 4: events at t0+6, t0+11, t0+16
    stop_i[0] = 1'b1; step(); stop_i[0] = 1'b0;
    cfg_mode_i[0] = 1'b1; cfg_reload_i[0 +: CW] = 16'd4; start_i[0] = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      step();
      start_i[0] = 1'b0;
      chk($sformatf("per_ev_t%0d", j), 32'(event_o[0]), 32'(j == 6 || j == 11 || j == 16));
      chk($sformatf("per_busy_t%0d", j), 32'(busy_o[0]), 32'd1);
    end
    stop_i[0] = 1'b1; step(); stop_i[0] = 1'b0;

    // one-shot reload 3 with prescaler divisor 3
    cfg_presc_i = 8'd2; cfg_mode_i[1] = 1'b0; cfg_reload_i[CW +: CW] = 16'd3; start_i[1] = 1'b1;
    n_ev = 0; lat = -1;
    for (int j = 1; j <= 40; j++) begin
      step();
      start_i[1] = 1'b0;
      if (event_o[1]) begin
        n_ev++;
        if (lat < 0) lat = j;
      end
    end
    chk("oneshot_count", 32'(n_ev), 32'd1);
    chk("oneshot_lat_ok", 32'(lat >= 3*(eff(2)+1)+2 && lat <= 3*(eff(2)+1)+2+eff(2)), 32'd1);
    chk("oneshot_busy", 32'(busy_o[1]), 32'd0);
    chk("oneshot_cnt", 32'(cnt_o[CW +: CW]), 32'd0);
    cfg_presc_i = 8'd0;

    // stop freezes the counter at 2, then start reloads
    cfg_mode_i[2] = 1'b1; cfg_reload_i[2*CW +: CW] = 16'd5; start_i[2] = 1'b1;
    step(); start_i[2] = 1'b0;
    k = 0;
    while (cnt_o[2*CW +: CW] != 16'd2 && k < 50) begin
      step();
      k++;
    end
    chk("stop_reach2", 32'(k < 50), 32'd1);
    stop_i[2] = 1'b1; step(); stop_i[2] = 1'b0;
    chk("stop_busy", 32'(busy_o[2]), 32'd0);
    chk("stop_cnt", 32'(cnt_o[2*CW +: CW]), 32'd2);
    n_ev = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (event_o[2]) n_ev++;
    end
    chk("stop_no_events", 32'(n_ev), 32'd0);
    chk("stop_frozen", 32'(cnt_o[2*CW +: CW]), 32'd2);
    start_i[2] = 1'b1; step(); start_i[2] = 1'b0;
    chk("restart_cnt", 32'(cnt_o[2*CW +: CW]), 32'd5);
    chk("restart_busy", 32'(busy_o[2]), 32'd1);

    // presc 7, reload 2 periodic: period 3 ticks of (presc+1) cycles when enabled
    cfg_presc_i = 8'd7; cfg_mode_i[3] = 1'b1; cfg_reload_i[3*CW +: CW] = 16'd2; start_i[3] = 1'b1;
    step(); start_i[3] = 1'b0;
    k = 0;
    while (!event_o[3] && k < 200) begin
      step();
      k++;
    end
    chk("presc_first_ev", 32'(k < 200), 32'd1);
    for (int r = 0; r < 2; r++) begin
      k = 0; seen = 0;
      while (!seen && k < 200) begin
        step();
        k++;
        seen = event_o[3];
      end
      chk($sformatf("presc_period%0d", r), 32'(k), 32'(3*(eff(7)+1)));
    end

    // async reset mid-count
    step();
    #3 rstn_i = 1'b0;
    #1 chk_reset_state("async");
    step();
    rstn_i = 1'b1;
    n_ev = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (event_o != '0) n_ev++;
    end
    chk("async_no_events", 32'(n_ev), 32'd0);
    chk("async_busy", 32'(busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
